pwm_peripheral: RTL and testbench

Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip outputs. Each output is forced low, held static high, or driven with a shared PWM waveform, according to its enable bits. A clock prescaler and an 8-bit period counter set the PWM frequency; the duty cycle is shadowed so waveform updates occur only at period boundaries.

---
 rtl/pwm_peripheral.sv | 122 ++++++++++++
 tb/tb_pwm_peripheral.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral
// Drives the 16 chip outputs from the SPI configuration registers. Each output
// is forced low, held static high, or follows one shared PWM waveform. A
// prescaler (divide by DIV) advances an 8-bit period counter, so one PWM
// period lasts 256*DIV clk cycles.
//
// Optional build macro: PWM_SHADOW_EN
//   defined   - duty cycle is captured into a shadow register at the period
//               boundary, so the waveform never changes mid-period.
//   undefined - the live duty cycle input is compared directly.
//
// Reset: rst_n is a synchronous, ACTIVE-HIGH reset despite its name.

module pwm_peripheral #(
    parameter int DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out
);

    localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);

    logic [PRE_W-1:0] pre_r;
    logic [7:0]       cnt_r;
    logic             tick_s;
    logic [7:0]       duty_eff_s;
    logic             lvl_s;
    logic [15:0]      eo_s;
    logic [15:0]      ep_s;
    logic [15:0]      out_next_s;
    logic [15:0]      out_r;

    assign tick_s = (pre_r == PRE_LAST);
    assign eo_s   = {en_reg_out_15_8, en_reg_out_7_0};
    assign ep_s   = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Prescaler: counts 0..DIV-1 and wraps; tick marks the last count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pre_r <= PRE_ZERO;
        end else if (tick_s) begin
            pre_r <= PRE_ZERO;
        end else begin
            pre_r <= pre_r + PRE_ONE;
        end
    end

    // Period counter: advances once per tick, wraps 255->0 with no gap.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_r <= 8'h00;
        end else if (tick_s) begin
            cnt_r <= cnt_r + 8'h01;
        end else begin
            cnt_r <= cnt_r;
        end
    end

`ifdef PWM_SHADOW_EN
    logic [7:0] duty_shadow_r;

    // Shadow duty: captured on the last tick of a period, governs the next one.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            duty_shadow_r <= 8'h00;
        end else if (tick_s && (cnt_r == 8'hFF)) begin
            duty_shadow_r <= pwm_duty_cycle;
        end else begin
            duty_shadow_r <= duty_shadow_r;
        end
    end

    assign duty_eff_s = duty_shadow_r;
`else
    assign duty_eff_s = pwm_duty_cycle;
`endif

    // PWM level: 8'hFF means always high, otherwise high while cnt < duty.
    always_comb begin
        lvl_s = 1'b0;
        if (duty_eff_s == 8'hFF) begin
            lvl_s = 1'b1;
        end else begin
            lvl_s = (cnt_r < duty_eff_s);
        end
    end

    // Per-output select: off when not enabled, PWM level or static high otherwise.
    always_comb begin
        out_next_s = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (!eo_s[i]) begin
                out_next_s[i] = 1'b0;
            end else if (ep_s[i]) begin
                out_next_s[i] = lvl_s;
            end else begin
                out_next_s[i] = 1'b1;
            end
        end
    end

    // Output register: one cycle of latency from counter/enables to the pins.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_r <= 16'h0000;
        end else begin
            out_r <= out_next_s;
        end
    end

    assign out = out_r;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral. Two instances share all inputs: one with
// DIV=1 and one with DIV=4. Outputs are sampled on the falling edge; sample k
// after reset release reflects cycle k, where cnt = k/DIV mod 256.
// Expectations that depend on PWM_SHADOW_EN are selected with the same macro.

module tb_pwm_peripheral;

    logic        clk;
    logic        rst_n;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] out1, out4;

    int tests_run;
    int tests_failed;
    int hi, bad, rises, falls;
    logic [15:0] v0, vx, prev;

`ifdef PWM_SHADOW_EN
    localparam int  SHD = 1;
`else
    localparam int  SHD = 0;
`endif

    pwm_peripheral #(.DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
        .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
        .pwm_duty_cycle(duty), .out(out1)
    );

    pwm_peripheral #(.DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
        .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
        .pwm_duty_cycle(duty), .out(out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: one reset edge, then released before the next.
    task automatic pulse_reset();
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b1;
        eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'hFF; ep_hi = 8'hFF;
        duty  = 8'h80;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_out_div1", 32'(out1), 32'h0);
            check_eq("rst_out_div4", 32'(out4), 32'h0);
        end
        check_eq("rst_cnt_div1", 32'(dut1.cnt_r), 32'h0);
        check_eq("rst_cnt_div4", 32'(dut4.cnt_r), 32'h0);
        check_eq("rst_pre_div4", 32'(dut4.pre_r), 32'h0);

        // 50% PWM on DIV=1
        rst_n = 1'b0;
        hi = 0; bad = 0; v0 = 16'h0; vx = 16'h0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (k == 0)   v0 = out1;
            if (k == 128) vx = out1;
            if (out1 == 16'hFFFF) hi++;
            else if (out1 != 16'h0000) bad++;
        end
        check_eq("p50_first_sample", 32'(v0), SHD ? 32'h0 : 32'hFFFF);
        check_eq("p50_sample128",    32'(vx), 32'h0);
        check_eq("p50_hi_period0",   32'(hi), SHD ? 32'd0 : 32'd128);
        check_eq("p50_partial_bits", 32'(bad), 32'd0);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (out1 == 16'hFFFF) hi++;
        end
        check_eq("p50_hi_period1", 32'(hi), 32'd128);

        // Static and off modes
        eo_lo = 8'hA5; eo_hi = 8'h00; ep_lo = 8'h00; ep_hi = 8'h00;
        @(negedge clk);
        check_eq("static_div1", 32'(out1), 32'h00A5);
        check_eq("static_div4", 32'(out4), 32'h00A5);
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            if (out1 != 16'h00A5) bad++;
            if (out4 != 16'h00A5) bad++;
        end
        check_eq("static_hold", 32'(bad), 32'd0);

        // Duty extremes on DIV=4
        eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'hFF; ep_hi = 8'hFF;
        duty = 8'h00;
        pulse_reset();
        bad = 0;
        for (int k = 0; k < 2048; k++) begin
            @(negedge clk);
            if (out4 != 16'h0000) bad++;
        end
        check_eq("duty00_low", 32'(bad), 32'd0);

        duty = 8'hFF;
        pulse_reset();
        repeat (1024) @(negedge clk);
        hi = 0;
        for (int k = 0; k < 2048; k++) begin
            @(negedge clk);
            if (out4 == 16'hFFFF) hi++;
        end
        check_eq("dutyFF_high", 32'(hi), 32'd2048);

        duty = 8'h01;
        pulse_reset();
        repeat (1024) @(negedge clk);
        hi = 0; v0 = 16'h0; vx = 16'hFFFF;
        for (int k = 0; k < 2048; k++) begin
            @(negedge clk);
            if (k == 0) v0 = out4;
            if (k == 4) vx = out4;
            if (out4 == 16'hFFFF) hi++;
        end
        check_eq("duty01_hi_cycles", 32'(hi), 32'd8);
        check_eq("duty01_start",     32'(v0), 32'hFFFF);
        check_eq("duty01_after4",    32'(vx), 32'h0);

        // Duty change 0x40 -> 0xC0 at cnt=10, DIV=1
        duty = 8'h40;
        pulse_reset();
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (out1 == 16'hFFFF) hi++;
        end
        check_eq("shd_period0_hi", 32'(hi), SHD ? 32'd0 : 32'd64);
        hi = 0; rises = 0; falls = 0; prev = 16'h0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (out1 == 16'hFFFF) hi++;
            if (k > 0 && prev == 16'h0000 && out1 == 16'hFFFF) rises++;
            if (k > 0 && prev == 16'hFFFF && out1 == 16'h0000) falls++;
            prev = out1;
            if (k == 9) duty = 8'hC0;
        end
        check_eq("shd_period1_hi",    32'(hi), SHD ? 32'd64 : 32'd192);
        check_eq("shd_period1_rises", 32'(rises), 32'd0);
        check_eq("shd_period1_falls", 32'(falls), 32'd1);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (out1 == 16'hFFFF) hi++;
        end
        check_eq("shd_period2_hi", 32'(hi), 32'd192);

        // Mixed modes on DIV=1
        eo_lo = 8'h00; ep_lo = 8'hFF; eo_hi = 8'hFF; ep_hi = 8'h0F;
        duty = 8'h40;
        pulse_reset();
        repeat (256) @(negedge clk);
        hi = 0; bad = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (out1[11:8] == 4'hF) hi++;
            if (out1[15:12] != 4'hF) bad++;
            if (out1[7:0] != 8'h00) bad++;
        end
        check_eq("mix_pwm_hi",   32'(hi), 32'd64);
        check_eq("mix_static",   32'(bad), 32'd0);
        for (int k = 0; k <= 100; k++) @(negedge clk);
        check_eq("mix_cnt100_pwm", 32'(out1[11:8]), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_reset_out", 32'(out1), 32'h0);
        rst_n = 1'b0;
        hi = 0; bad = 0; v0 = 16'h0; vx = 16'hFFFF;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (k == 0)   v0 = out1;
            if (k == 255) vx = out1;
            if (out1[11:8] == 4'hF) hi++;
            if (out1[15:12] != 4'hF) bad++;
        end
        check_eq("restart_first",  32'(v0[11:8]), SHD ? 32'h0 : 32'hF);
        check_eq("restart_hi",     32'(hi), SHD ? 32'd0 : 32'd64);
        check_eq("restart_static", 32'(bad), 32'd0);
        check_eq("restart_last",   32'(vx[11:8]), 32'h0);
        @(negedge clk);
        check_eq("restart_next_period", 32'(out1[11:8]), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
